regfile_wb_sequencer: RTL

Write-back sequencer that drives the register file's write port (`RegWrite`, `instr`, `Writedata`). It buffers completed results arriving over a valid/ready handshake and retires one per cycle as a formatted write. It also exposes a pending-write scoreboard so operand fetch can detect read-after-write hazards against queued results. It sits between the execute/result stage and the register file.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 50 +++++
 rtl/regfile_wb_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and bundle types for the register-file write-back path.
// Included first; imported by wb_fifo and regfile_wb_sequencer.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int RD_LSB     = 11;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // Write word carries only the destination field; every other bit is zero.
  function automatic logic [DATA_W-1:0] wb_instr(
    input logic [REG_ADDR_W-1:0] dst
  );
    logic [DATA_W-1:0] w;
    w = '0;
    w[RD_LSB +: REG_ADDR_W] = dst;
    return w;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous result FIFO with count/full/empty.
// All slots are exported so the sequencer can scan pending writes.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  wb_entry_t             wr_entry,
  input  logic                  pop,
  output wb_entry_t [DEPTH-1:0] entries,
  output logic [PW-1:0]         head,
  output logic [PW:0]           count,
  output logic                  full,
  output logic                  empty
);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0] tail;
  logic wr;
  logic rd;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr      = push && !full;
  assign rd      = pop && !empty;
  assign entries = mem;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr) tail <= tail + 1'b1;
      if (rd) head <= head + 1'b1;
      count <= count + (PW+1)'(wr) - (PW+1)'(rd);
    end
  end

  // Slot contents need no reset; validity comes from head/count.
  always_ff @(posedge clk) begin
    if (wr && !reset && !clear) mem[tail] <= wr_entry;
  end

endmodule

// File: rtl/regfile_wb_sequencer.sv
// Buffers results and retires one register-file write per cycle.
// Define REGFILE_WB_BYPASS_EN to forward youngest pending data on q_*_data.
module regfile_wb_sequencer
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [REG_ADDR_W-1:0] res_dst,
  input  logic [DATA_W-1:0]     res_data,
  input  logic                  flush,
  input  logic                  wb_stall,
  output logic                  RegWrite,
  output logic [DATA_W-1:0]     instr,
  output logic [DATA_W-1:0]     Writedata,
  input  logic [REG_ADDR_W-1:0] q_rs,
  input  logic [REG_ADDR_W-1:0] q_rt,
  output logic                  q_rs_busy,
  output logic                  q_rt_busy,
  output logic [DATA_W-1:0]     q_rs_data,
  output logic [DATA_W-1:0]     q_rt_data
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] entries;
  wb_entry_t             head_e;
  logic [PW-1:0]         head;
  logic [PW:0]           count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  assign res_ready = !full;
  // x0 writes complete the handshake but are never stored.
  assign push   = res_valid && !full && !flush && (res_dst != '0);
  assign pop    = !empty && !wb_stall && !flush;
  assign head_e = entries[head];

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .push     (push),
    .wr_entry ('{dst: res_dst, data: res_data}),
    .pop      (pop),
    .entries  (entries),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite  <= 1'b0;
      instr     <= '0;
      Writedata <= '0;
    end else if (pop) begin
      RegWrite  <= 1'b1;
      instr     <= wb_instr(head_e.dst);
      Writedata <= head_e.data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  function automatic logic slot_hit(
    input int k,
    input logic [REG_ADDR_W-1:0] q
  );
    logic [PW-1:0] idx;
    idx = head + PW'(k);
    return ((PW+1)'(k) < count) && (entries[idx].dst == q);
  endfunction

  function automatic logic sb_busy(input logic [REG_ADDR_W-1:0] q);
    logic busy;
    busy = RegWrite && (instr[RD_LSB +: REG_ADDR_W] == q);
    for (int k = 0; k < DEPTH; k++) begin
      if (slot_hit(k, q)) busy = 1'b1;
    end
    return busy && (q != '0);
  endfunction

  assign q_rs_busy = sb_busy(q_rs);
  assign q_rt_busy = sb_busy(q_rt);

`ifdef REGFILE_WB_BYPASS_EN
  // Scan oldest to youngest so the tail-most match wins.
  function automatic logic [DATA_W-1:0] sb_data(
    input logic [REG_ADDR_W-1:0] q
  );
    logic [DATA_W-1:0] d;
    logic [PW-1:0] idx;
    d = '0;
    if (RegWrite && (instr[RD_LSB +: REG_ADDR_W] == q)) d = Writedata;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (slot_hit(k, q)) d = entries[idx].data;
    end
    return (q == '0) ? '0 : d;
  endfunction

  assign q_rs_data = sb_data(q_rs);
  assign q_rt_data = sb_data(q_rt);
`else
  assign q_rs_data = '0;
  assign q_rt_data = '0;
`endif

endmodule
